// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC/redirect/stall inputs, instruction memory port, F/D register outputs.
// Latency: none (wiring only).
// Backpressure: stall holds the stage; branch_taken squashes and overrides stall.
interface fetch_stage_if #(
    parameter int IMEM_AW = 12
);
    logic [31:0]        pc_cur;
    logic               stall;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic [31:0]        imem_data;
    logic [31:0]        pc_next;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        fd_pc;
    logic [31:0]        fd_pc_plus1;
    logic [31:0]        fd_insn;
    logic               fd_valid;

    // Environment side: PC register, hazard/execute logic and instruction memory.
    modport master (
        output pc_cur, stall, branch_taken, branch_target, imem_data,
        input  pc_next, imem_addr, fd_pc, fd_pc_plus1, fd_insn, fd_valid
    );

    // Fetch stage side.
    modport slave (
        input  pc_cur, stall, branch_taken, branch_target, imem_data,
        output pc_next, imem_addr, fd_pc, fd_pc_plus1, fd_insn, fd_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: next-PC select, sync imem addressing, F2 tracking register and F/D register.
// Latency: 2 edges from PC to F/D; redirect costs 2 bubbles.
// Backpressure: stall freezes F2/F/D and replays the F2 address; branch_taken wins over stall.
module fetch_stage #(
    parameter int          IMEM_AW  = 12,
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_stage_if.slave bus
);

    // F2 records which address the memory is returning this cycle.
    logic [31:0]        f2_pc_q, f2_pc_d;
    logic               f2_valid_q, f2_valid_d;
    logic [31:0]        fd_pc_q, fd_pc_d;
    logic [31:0]        fd_insn_q, fd_insn_d;
    logic               fd_valid_q, fd_valid_d;
    logic [31:0]        pc_next;
    logic [IMEM_AW-1:0] imem_addr;

    // Mode select (redirect > hold > run) and next-state for F2 and F/D.
    always_comb begin
        f2_pc_d    = f2_pc_q;
        f2_valid_d = f2_valid_q;
        fd_pc_d    = fd_pc_q;
        fd_insn_d  = fd_insn_q;
        fd_valid_d = fd_valid_q;
        pc_next    = bus.pc_cur + 32'd1;
        imem_addr  = bus.pc_cur[IMEM_AW-1:0];

        if (bus.branch_taken) begin
            // Squash both stages; f2_pc is don't-care while f2_valid is low.
            pc_next    = bus.branch_target;
            f2_valid_d = 1'b0;
            fd_valid_d = 1'b0;
            fd_insn_d  = NOP_INSN;
            fd_pc_d    = 32'd0;
        end else if (bus.stall) begin
            // Re-read the F2 address so imem_data still matches f2_pc after the stall.
            pc_next   = bus.pc_cur;
            imem_addr = f2_pc_q[IMEM_AW-1:0];
        end else begin
            f2_pc_d    = bus.pc_cur;
            f2_valid_d = 1'b1;
            fd_valid_d = f2_valid_q;
            fd_pc_d    = f2_valid_q ? f2_pc_q       : 32'd0;
            fd_insn_d  = f2_valid_q ? bus.imem_data : NOP_INSN;
        end
    end

    // State registers with immediate asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f2_pc_q    <= 32'd0;
            f2_valid_q <= 1'b0;
            fd_pc_q    <= 32'd0;
            fd_insn_q  <= NOP_INSN;
            fd_valid_q <= 1'b0;
        end else begin
            f2_pc_q    <= f2_pc_d;
            f2_valid_q <= f2_valid_d;
            fd_pc_q    <= fd_pc_d;
            fd_insn_q  <= fd_insn_d;
            fd_valid_q <= fd_valid_d;
        end
    end

    assign bus.pc_next     = pc_next;
    assign bus.imem_addr   = imem_addr;
    assign bus.fd_pc       = fd_pc_q;
    assign bus.fd_pc_plus1 = fd_pc_q + 32'd1;
    assign bus.fd_insn     = fd_insn_q;
    assign bus.fd_valid    = fd_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: PC register and synchronous memory models around the DUT,
// vector table for the main pipeline trace, hand sequences for reset and PC wrap.
module tb_fetch_stage;

    localparam int          AW  = 12;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        exp_vld;
        logic [31:0] exp_fd_pc;
        logic [31:0] exp_insn;
        logic [31:0] exp_pc_next;
        logic [31:0] exp_addr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = 32'd0;
    logic        pc_force = 1'b0;
    logic [31:0] pc_force_val = 32'd0;
    logic [31:0] pc_q;
    logic [31:0] mem_q;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    fetch_stage_if #(.IMEM_AW(AW)) bus ();

    fetch_stage #(.IMEM_AW(AW), .NOP_INSN(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.pc_cur        = pc_q;
    assign bus.stall         = stall;
    assign bus.branch_taken  = br;
    assign bus.branch_target = tgt;
    assign bus.imem_data     = mem_q;

    always #5 clk = ~clk;

    // Program counter register, with a bench-only load path for the wrap case.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        pc_q <= 32'd0;
        else if (pc_force) pc_q <= pc_force_val;
        else               pc_q <= bus.pc_next;
    end

    // Synchronous instruction memory: word i holds A000_0000 + i.
    always_ff @(posedge clk) begin
        mem_q <= 32'hA000_0000 + {20'd0, bus.imem_addr};
    end

    function automatic logic [31:0] w(input logic [31:0] i);
        return 32'hA000_0000 + i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic b, input logic [31:0] t, input logic v,
                       input logic [31:0] fp, input logic [31:0] ins,
                       input logic [31:0] pn, input logic [31:0] ad);
        vec_t x;
        x.stall = s; x.br = b; x.tgt = t; x.exp_vld = v; x.exp_fd_pc = fp;
        x.exp_insn = ins; x.exp_pc_next = pn; x.exp_addr = ad;
        vecs.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // cycle: stall br target | fd_valid fd_pc fd_insn | pc_next imem_addr
        add(0, 0, 0,     0, 0,     NOP,     32'h01, 32'h00);  // 0
        add(0, 0, 0,     0, 0,     NOP,     32'h02, 32'h01);  // 1
        add(0, 0, 0,     1, 0,     w(0),    32'h03, 32'h02);  // 2
        add(0, 0, 0,     1, 1,     w(1),    32'h04, 32'h03);  // 3
        add(0, 0, 0,     1, 2,     w(2),    32'h05, 32'h04);  // 4
        add(0, 0, 0,     1, 3,     w(3),    32'h06, 32'h05);  // 5
        add(0, 0, 0,     1, 4,     w(4),    32'h07, 32'h06);  // 6
        add(1, 0, 0,     1, 5,     w(5),    32'h07, 32'h06);  // 7  stall, addr = f2_pc
        add(1, 0, 0,     1, 5,     w(5),    32'h07, 32'h06);  // 8
        add(1, 0, 0,     1, 5,     w(5),    32'h07, 32'h06);  // 9
        add(0, 0, 0,     1, 5,     w(5),    32'h08, 32'h07);  // 10 released
        add(0, 0, 0,     1, 6,     w(6),    32'h09, 32'h08);  // 11
        add(0, 1, 32'h40, 1, 7,    w(7),    32'h40, 32'h09);  // 12 redirect
        add(0, 0, 0,     0, 0,     NOP,     32'h41, 32'h40);  // 13
        add(0, 0, 0,     0, 0,     NOP,     32'h42, 32'h41);  // 14
        add(0, 0, 0,     1, 32'h40, w(32'h40), 32'h43, 32'h42); // 15
        add(1, 1, 32'h80, 1, 32'h41, w(32'h41), 32'h80, 32'h43); // 16 stall+branch
        add(1, 0, 0,     0, 0,     NOP,     32'h80, 32'h42);  // 17 hold, f2_pc untouched by squash
        add(1, 1, 32'h80, 0, 0,    NOP,     32'h80, 32'h80);  // 18 redirect while stalled
        add(0, 0, 0,     0, 0,     NOP,     32'h81, 32'h80);  // 19
        add(0, 0, 0,     0, 0,     NOP,     32'h82, 32'h81);  // 20
        add(0, 0, 0,     1, 32'h80, w(32'h80), 32'h83, 32'h82); // 21
        add(0, 0, 0,     1, 32'h81, w(32'h81), 32'h84, 32'h83); // 22

        // Power-on reset, released between edges.
        repeat (2) @(posedge clk);
        #1;
        chk("por_fd_valid", {31'd0, bus.fd_valid}, 32'd0);
        chk("por_fd_insn", bus.fd_insn, NOP);
        reset = 1'b1;

        foreach (vecs[i]) begin
            stall = vecs[i].stall;
            br    = vecs[i].br;
            tgt   = vecs[i].tgt;
            #1;
            chk($sformatf("v%0d_fd_valid", i), {31'd0, bus.fd_valid}, {31'd0, vecs[i].exp_vld});
            chk($sformatf("v%0d_fd_pc", i), bus.fd_pc, vecs[i].exp_fd_pc);
            chk($sformatf("v%0d_fd_pc_plus1", i), bus.fd_pc_plus1, vecs[i].exp_fd_pc + 32'd1);
            chk($sformatf("v%0d_fd_insn", i), bus.fd_insn, vecs[i].exp_insn);
            chk($sformatf("v%0d_pc_next", i), bus.pc_next, vecs[i].exp_pc_next);
            chk($sformatf("v%0d_imem_addr", i), {20'd0, bus.imem_addr}, vecs[i].exp_addr);
            step();
        end

        // Reset asserted mid-stall with a redirect pending: clears at once, no residue.
        stall = 1'b1; br = 1'b1; tgt = 32'h80;
        #1;
        reset = 1'b0;
        #1;
        chk("rst_fd_valid", {31'd0, bus.fd_valid}, 32'd0);
        chk("rst_fd_pc", bus.fd_pc, 32'd0);
        chk("rst_fd_insn", bus.fd_insn, NOP);
        chk("rst_f2_valid", {31'd0, dut.f2_valid_q}, 32'd0);
        step();
        stall = 1'b0; br = 1'b0; tgt = 32'd0;
        reset = 1'b1;
        #1;
        chk("rel_pc_next", bus.pc_next, 32'd1);
        step();
        chk("rel_e1_fd_valid", {31'd0, bus.fd_valid}, 32'd0);
        step();
        chk("rel_e2_fd_valid", {31'd0, bus.fd_valid}, 32'd1);
        chk("rel_e2_fd_pc", bus.fd_pc, 32'd0);
        chk("rel_e2_fd_insn", bus.fd_insn, w(0));

        // PC wrap at the top of the address space.
        pc_force = 1'b1; pc_force_val = 32'hFFFF_FFFF;
        step();
        pc_force = 1'b0;
        #1;
        chk("wrap_pc_next", bus.pc_next, 32'd0);
        chk("wrap_imem_addr", {20'd0, bus.imem_addr}, 32'h0000_0FFF);
        step();
        step();
        chk("wrap_fd_pc", bus.fd_pc, 32'hFFFF_FFFF);
        chk("wrap_fd_insn", bus.fd_insn, w(32'h0FFF));
        chk("wrap_fd_pc_plus1", bus.fd_pc_plus1, 32'd0);
        chk("wrap_fd_valid", {31'd0, bus.fd_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
